ctrl_seq: RTL

- Instruction-cycle controller for the 8-bit RISC processor.
- Sequences an 8-phase fetch/execute cycle and drives the strobes for IR, PC, accumulator, address mux and memory bus.
- Consumes the 3-bit opcode held in the instruction register and the ALU zero flag.
- Sits beside the datapath. It is the only source of ldir and the memory read/write strobes.

---
 rtl/ctrl_pkg.sv | 14 +
 rtl/ctrl_seq_if.sv | 22 ++
 rtl/ctrl_dec.sv | 26 ++
 rtl/ctrl_seq.sv | 50 +++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, phase names, strobe bundle and sequencer modes shared by the controller.
package ctrl_pkg;
    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
                           XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
    localparam logic [2:0] INST_ADDR = 3'd0, INST_FETCH = 3'd1, INST_LOAD = 3'd2, IDLE = 3'd3,
                           OP_ADDR = 3'd4, OP_FETCH = 3'd5, ALU_OP = 3'd6, STORE = 3'd7;
    typedef struct packed {
        logic sel, rd, ldir, inc_pc, ldpc, ldac, data_e, wr;
    } strobe_t;
    typedef enum logic [1:0] {RUN, STALL, HALTED} mode_t;
    function automatic logic is_aluop(input logic [2:0] op);
        return op inside {ADD, AND, XOR, LDA};
    endfunction
endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: controller <-> datapath bundle; step exists only with CTRL_SEQ_STEP_EN.
interface ctrl_seq_if #(parameter int OPW = 3, parameter int PHW = 3);
    logic [OPW-1:0] opcd;
    logic           zero;
`ifdef CTRL_SEQ_STEP_EN
    logic           step;
`endif
    logic           sel, rd, ldir, inc_pc, ldpc, ldac, data_e, wr, halt;
    logic [PHW-1:0] phase;
    modport master(
`ifdef CTRL_SEQ_STEP_EN
        input step,
`endif
        input opcd, zero,
        output sel, rd, ldir, inc_pc, ldpc, ldac, data_e, wr, halt, phase);
    modport slave(
`ifdef CTRL_SEQ_STEP_EN
        output step,
`endif
        output opcd, zero,
        input sel, rd, ldir, inc_pc, ldpc, ldac, data_e, wr, halt, phase);
endinterface

// File: rtl/ctrl_dec.sv
// ctrl_dec: combinational phase/opcode to strobe decode; everything is forced low while halted.
module ctrl_dec import ctrl_pkg::*; #(parameter int OPW = 3, parameter int PHW = 3) (
    input  logic [PHW-1:0] phase_i,
    input  logic [OPW-1:0] opcd_i,
    input  logic           zero_i,
    input  logic           halt_i,
    output strobe_t        strb_o
);
    logic [2:0] op;
    logic       alu;
    assign op  = 3'(opcd_i);
    assign alu = is_aluop(op);
    always_comb begin
        strb_o = '0;
        if (!halt_i) begin
            strb_o.sel    = phase_i <= IDLE;
            strb_o.rd     = (phase_i >= INST_FETCH && phase_i <= IDLE) || (phase_i >= OP_FETCH && alu);
            strb_o.ldir   = phase_i == INST_LOAD || phase_i == IDLE;
            strb_o.inc_pc = phase_i == OP_ADDR || (phase_i == ALU_OP && op == SKZ && zero_i);
            strb_o.ldpc   = phase_i >= ALU_OP && op == JMP;
            strb_o.ldac   = phase_i == STORE && alu;
            strb_o.data_e = phase_i >= ALU_OP && op == STO;
            strb_o.wr     = phase_i == STORE && op == STO;
        end
    end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: 8-phase fetch/execute sequencer with halt; CTRL_SEQ_STEP_EN adds a single-step stall at each wrap.
module ctrl_seq import ctrl_pkg::*; #(parameter int OPW = 3, parameter int PHW = 3) (
    input logic        clk,
    input logic        rst,
    ctrl_seq_if.master bus
);
    mode_t          mode_q, mode_d;
    logic [PHW-1:0] phase_q, phase_d;
    logic           step;
    strobe_t        strb;
`ifdef CTRL_SEQ_STEP_EN
    assign step = bus.step;
`else
    assign step = 1'b1;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= RUN;
            phase_q <= '0;
        end else begin
            mode_q  <= mode_d;
            phase_q <= phase_d;
        end
    end
    // A stall releasing on step goes straight on to phase 1, like a normal phase-0 clock.
    always_comb begin
        mode_d  = mode_q;
        phase_d = (mode_q == HALTED || (mode_q == STALL && !step)) ? phase_q : phase_q + 1'b1;
        if (mode_q == STALL && step)
            mode_d = RUN;
        else if (mode_q == RUN && phase_q == PHW'(OP_ADDR) && bus.opcd == OPW'(HLT))
            mode_d = HALTED;
        else if (mode_q == RUN && phase_q == PHW'(STORE) && !step)
            mode_d = STALL;
    end
    ctrl_dec #(.OPW(OPW), .PHW(PHW)) u_dec (
        .phase_i(phase_q), .opcd_i(bus.opcd), .zero_i(bus.zero),
        .halt_i(mode_q == HALTED), .strb_o(strb)
    );
    assign bus.sel    = strb.sel;
    assign bus.rd     = strb.rd;
    assign bus.ldir   = strb.ldir;
    assign bus.inc_pc = strb.inc_pc;
    assign bus.ldpc   = strb.ldpc;
    assign bus.ldac   = strb.ldac;
    assign bus.data_e = strb.data_e;
    assign bus.wr     = strb.wr;
    assign bus.halt   = mode_q == HALTED;
    assign bus.phase  = phase_q;
endmodule
